// File: rtl/obstacle_scheduler.sv
// Cactus obstacle scheduler: spawns, scrolls and retires two sprite slots.
// Spawn spacing is a minimum scroll gap plus a masked byte from a Galois LFSR.
module obstacle_scheduler #(
  parameter int          H_DISP    = 800,
  parameter int          MIN_GAP   = 200,
  parameter logic [7:0]  GAP_MASK  = 8'hFF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        is_living,
  input  logic        is_dying,
  input  logic [3:0]  move_rate,
  output logic        cactus_vld_0,
  output logic [10:0] cactus_x_0,
  output logic        cactus_vld_1,
  output logic [10:0] cactus_x_1,
  output logic        spawn_pulse,
  output logic [15:0] passed_cnt
);
  localparam logic [10:0] X_SPAWN = 11'(H_DISP);
  localparam logic [10:0] GAP_MIN = 11'(MIN_GAP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FREEZE} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]       r_vld, w_vld_nxt;
  logic [1:0][10:0] r_x, w_x_nxt;
  logic [10:0]      r_gap, w_gap_nxt, w_rate;
  logic             r_pulse, w_pulse_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [15:0]      r_lfsr, w_lfsr_nxt;
  logic [1:0]       w_retire, w_nret;
  logic [16:0]      w_sum;
  logic             w_tick;

  assign w_rate     = {7'd0, move_rate};
  // A dying request wins over a tick in the same cycle, so that tick is lost.
  assign w_tick     = (r_state == S_RUN) && frame_tick && !is_dying;
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (is_living) w_state_nxt = S_RUN;
      S_RUN:   if (is_dying)  w_state_nxt = S_FREEZE;
      default: w_state_nxt = S_FREEZE;
    endcase
  end

  always_comb begin
    w_vld_nxt   = r_vld;
    w_x_nxt     = r_x;
    w_gap_nxt   = r_gap;
    w_pulse_nxt = 1'b0;
    w_retire    = '0;
    if (w_tick) begin
      for (int i = 0; i < 2; i++) begin
        if (r_vld[i]) begin
          if (r_x[i] < w_rate) begin
            w_retire[i]  = 1'b1;
            w_vld_nxt[i] = 1'b0;
            w_x_nxt[i]   = X_SPAWN;
          end else begin
            w_x_nxt[i]   = r_x[i] - w_rate;
          end
        end
      end
      // Freeness is judged on pre-tick valids, so a slot retiring now stays busy.
      if (r_gap <= w_rate) begin
        if (!r_vld[0] || !r_vld[1]) begin
          if (!r_vld[0]) begin
            w_vld_nxt[0] = 1'b1;
            w_x_nxt[0]   = X_SPAWN;
          end else begin
            w_vld_nxt[1] = 1'b1;
            w_x_nxt[1]   = X_SPAWN;
          end
          w_gap_nxt   = GAP_MIN + {3'd0, r_lfsr[7:0] & GAP_MASK};
          w_pulse_nxt = 1'b1;
        end else begin
          w_gap_nxt = '0;
        end
      end else begin
        w_gap_nxt = r_gap - w_rate;
      end
    end
    w_nret    = {1'b0, w_retire[0]} + {1'b0, w_retire[1]};
    w_sum     = {1'b0, r_cnt} + {15'd0, w_nret};
    w_cnt_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  always_ff @(posedge lcd_pclk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_x     <= {X_SPAWN, X_SPAWN};
      r_gap   <= '0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_vld   <= w_vld_nxt;
      r_x     <= w_x_nxt;
      r_gap   <= w_gap_nxt;
      r_pulse <= w_pulse_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  assign cactus_vld_0 = r_vld[0];
  assign cactus_x_0   = r_x[0];
  assign cactus_vld_1 = r_vld[1];
  assign cactus_x_1   = r_x[1];
  assign spawn_pulse  = r_pulse;
  assign passed_cnt   = r_cnt;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: four instances with different gap
// settings share one stimulus stream; each scenario task checks its own values.
module tb_obstacle_scheduler;
  logic        lcd_pclk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        is_living = 1'b0;
  logic        is_dying = 1'b0;
  logic [3:0]  move_rate = 4'd4;
  logic [3:0]  vld0, vld1, pulse;
  logic [10:0] x0 [4];
  logic [10:0] x1 [4];
  logic [15:0] pc [4];
  logic [10:0] hx [4] = '{11'd800, 11'd800, 11'd800, 11'd0};
  int          errs = 0;
  int          checks = 0;
  int          tcount = 0;

  always #5 lcd_pclk = ~lcd_pclk;

  obstacle_scheduler u0 (
    .lcd_pclk(lcd_pclk), .rst(rst), .frame_tick(frame_tick), .is_living(is_living),
    .is_dying(is_dying), .move_rate(move_rate), .cactus_vld_0(vld0[0]), .cactus_x_0(x0[0]),
    .cactus_vld_1(vld1[0]), .cactus_x_1(x1[0]), .spawn_pulse(pulse[0]), .passed_cnt(pc[0]));
  obstacle_scheduler #(.MIN_GAP(200), .GAP_MASK(8'h00)) u1 (
    .lcd_pclk(lcd_pclk), .rst(rst), .frame_tick(frame_tick), .is_living(is_living),
    .is_dying(is_dying), .move_rate(move_rate), .cactus_vld_0(vld0[1]), .cactus_x_0(x0[1]),
    .cactus_vld_1(vld1[1]), .cactus_x_1(x1[1]), .spawn_pulse(pulse[1]), .passed_cnt(pc[1]));
  obstacle_scheduler #(.MIN_GAP(8), .GAP_MASK(8'h00)) u2 (
    .lcd_pclk(lcd_pclk), .rst(rst), .frame_tick(frame_tick), .is_living(is_living),
    .is_dying(is_dying), .move_rate(move_rate), .cactus_vld_0(vld0[2]), .cactus_x_0(x0[2]),
    .cactus_vld_1(vld1[2]), .cactus_x_1(x1[2]), .spawn_pulse(pulse[2]), .passed_cnt(pc[2]));
  obstacle_scheduler #(.H_DISP(0), .MIN_GAP(0), .GAP_MASK(8'h00)) u3 (
    .lcd_pclk(lcd_pclk), .rst(rst), .frame_tick(frame_tick), .is_living(is_living),
    .is_dying(is_dying), .move_rate(move_rate), .cactus_vld_0(vld0[3]), .cactus_x_0(x0[3]),
    .cactus_vld_1(vld1[3]), .cactus_x_1(x1[3]), .spawn_pulse(pulse[3]), .passed_cnt(pc[3]));

  // One frame tick; returns on the falling edge where its effects are visible.
  task automatic tick(input logic [3:0] rate);
    @(negedge lcd_pclk);
    move_rate  = rate;
    frame_tick = 1'b1;
    @(negedge lcd_pclk);
    frame_tick = 1'b0;
    tcount++;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    @(negedge lcd_pclk);
    @(negedge lcd_pclk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (x0[k] !== hx[k] || x1[k] !== hx[k]) begin
        errs++;
        $display("FAIL reset_x[%0d]: got %0d/%0d want %0d", k, x0[k], x1[k], hx[k]);
      end
      checks++;
      if (pc[k] !== 16'd0) begin
        errs++;
        $display("FAIL reset_passed[%0d]: got %0d want 0", k, pc[k]);
      end
    end
    checks++;
    if ({vld0, vld1, pulse} !== 12'h000) begin
      errs++;
      $display("FAIL reset_flags: got %h want 000", {vld0, vld1, pulse});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(4'd4);
      if (pulse !== 4'b0000) seen = 1'b1;
    end
    checks++;
    if (seen || {vld0, vld1} !== 8'h00 || x0[0] !== 11'd800 || x1[0] !== 11'd800) begin
      errs++;
      $display("FAIL idle_hold: pulse_seen=%0b vld=%h x0=%0d x1=%0d want 0/00/800/800",
               seen, {vld0, vld1}, x0[0], x1[0]);
    end
    checks++;
    if (pc[0] !== 16'd0) begin
      errs++;
      $display("FAIL idle_passed: got %0d want 0", pc[0]);
    end
    tcount = 0;
  endtask

  task automatic test_spawn_move;
    @(negedge lcd_pclk);
    is_living = 1'b1;
    @(negedge lcd_pclk);
    while (tcount < 11) begin
      tick(4'd4);
      if (tcount == 1) begin
        checks++;
        if (vld0[0] !== 1'b1 || x0[0] !== 11'd800 || pulse !== 4'b1111) begin
          errs++;
          $display("FAIL first_spawn: vld=%b x0=%0d pulse=%b want 1/800/1111", vld0[0], x0[0], pulse);
        end
        @(negedge lcd_pclk);
        checks++;
        if (pulse !== 4'b0000) begin
          errs++;
          $display("FAIL pulse_width: got %b want 0000", pulse);
        end
      end
      if (tcount == 2) begin
        checks++;
        if (x0[0] !== 11'd796) begin
          errs++;
          $display("FAIL move_t2: got %0d want 796", x0[0]);
        end
      end
      if (tcount == 3) begin
        checks++;
        if (vld1[2] !== 1'b1 || x1[2] !== 11'd800 || pulse[2] !== 1'b1) begin
          errs++;
          $display("FAIL short_gap_spawn: vld1=%b x1=%0d pulse=%b want 1/800/1", vld1[2], x1[2], pulse[2]);
        end
      end
      if (tcount == 5) begin
        checks++;
        if (pulse[2] !== 1'b0 || vld0[2] !== 1'b1 || vld1[2] !== 1'b1) begin
          errs++;
          $display("FAIL full_no_spawn: pulse=%b vld=%b%b want 0/11", pulse[2], vld0[2], vld1[2]);
        end
      end
    end
    checks++;
    if (x0[0] !== 11'd760) begin
      errs++;
      $display("FAIL move_t11: got %0d want 760", x0[0]);
    end
  endtask

  task automatic test_gap;
    while (tcount < 51) begin
      tick(4'd4);
      if (tcount == 50) begin
        checks++;
        if (vld1[1] !== 1'b0) begin
          errs++;
          $display("FAIL gap_early: vld1=%b want 0", vld1[1]);
        end
      end
    end
    checks++;
    if (vld1[1] !== 1'b1 || x1[1] !== 11'd800 || x0[1] !== 11'd600 || pulse[1] !== 1'b1) begin
      errs++;
      $display("FAIL gap_spawn: vld1=%b x1=%0d x0=%0d pulse=%b want 1/800/600/1",
               vld1[1], x1[1], x0[1], pulse[1]);
    end
  endtask

  task automatic test_retire;
    while (tcount < 204) begin
      tick(4'd4);
      if (tcount == 201) begin
        checks++;
        if (vld0[2] !== 1'b1 || x0[2] !== 11'd0 || pc[2] !== 16'd0) begin
          errs++;
          $display("FAIL at_edge: vld=%b x0=%0d pc=%0d want 1/0/0", vld0[2], x0[2], pc[2]);
        end
      end
      if (tcount == 202) begin
        checks++;
        if (vld0[2] !== 1'b0 || x0[2] !== 11'd800 || pc[2] !== 16'd1 || x1[2] !== 11'd4) begin
          errs++;
          $display("FAIL retire: vld=%b x0=%0d pc=%0d x1=%0d want 0/800/1/4", vld0[2], x0[2], pc[2], x1[2]);
        end
      end
      if (tcount == 203) begin
        checks++;
        if (vld0[2] !== 1'b1 || x0[2] !== 11'd800 || pulse[2] !== 1'b1 || x1[2] !== 11'd0 || pc[2] !== 16'd1) begin
          errs++;
          $display("FAIL respawn: vld=%b x0=%0d pulse=%b x1=%0d pc=%0d want 1/800/1/0/1",
                   vld0[2], x0[2], pulse[2], x1[2], pc[2]);
        end
      end
    end
    checks++;
    if (vld1[2] !== 1'b0 || x1[2] !== 11'd800 || pc[2] !== 16'd2 || x0[2] !== 11'd796 || pulse[2] !== 1'b0) begin
      errs++;
      $display("FAIL retire_slot1: vld1=%b x1=%0d pc=%0d x0=%0d pulse=%b want 0/800/2/796/0",
               vld1[2], x1[2], pc[2], x0[2], pulse[2]);
    end
  endtask

  task automatic test_rate_change;
    @(negedge lcd_pclk);
    rst = 1'b1;
    @(negedge lcd_pclk);
    rst = 1'b0;
    tcount = 0;
    while (tcount < 19) tick(4'd4);
    checks++;
    if (x0[0] !== 11'd728) begin
      errs++;
      $display("FAIL pre_stop: got %0d want 728", x0[0]);
    end
    while (tcount < 24) begin
      tick(4'd0);
      checks++;
      if (x0[0] !== 11'd728 || vld0[0] !== 1'b1) begin
        errs++;
        $display("FAIL rate0_hold t%0d: x0=%0d vld=%b want 728/1", tcount, x0[0], vld0[0]);
      end
    end
    tick(4'd7);
    checks++;
    if (x0[0] !== 11'd721) begin
      errs++;
      $display("FAIL rate7_first: got %0d want 721", x0[0]);
    end
    while (tcount < 28) tick(4'd7);
    checks++;
    if (x0[0] !== 11'd700 || vld1[0] !== 1'b0 || pc[0] !== 16'd0) begin
      errs++;
      $display("FAIL rate7_run: x0=%0d vld1=%b pc=%0d want 700/0/0", x0[0], vld1[0], pc[0]);
    end
  endtask

  task automatic test_freeze;
    @(negedge lcd_pclk);
    is_dying   = 1'b1;
    frame_tick = 1'b1;
    move_rate  = 4'd7;
    @(negedge lcd_pclk);
    frame_tick = 1'b0;
    checks++;
    if (x0[0] !== 11'd700 || vld0[0] !== 1'b1 || pulse[0] !== 1'b0) begin
      errs++;
      $display("FAIL dying_tick: x0=%0d vld=%b pulse=%b want 700/1/0", x0[0], vld0[0], pulse[0]);
    end
    for (int i = 0; i < 10; i++) begin
      tick(4'(i + 3));
      checks++;
      if (x0[0] !== 11'd700 || vld0[0] !== 1'b1 || pulse[0] !== 1'b0 || pc[0] !== 16'd0) begin
        errs++;
        $display("FAIL frozen %0d: x0=%0d vld=%b pulse=%b pc=%0d want 700/1/0/0",
                 i, x0[0], vld0[0], pulse[0], pc[0]);
      end
    end
    @(negedge lcd_pclk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (x0[0] !== 11'd800 || vld0[0] !== 1'b0 || x0[2] !== 11'd800 || pc[2] !== 16'd0) begin
      errs++;
      $display("FAIL async_reset: x0=%0d vld=%b u2x0=%0d u2pc=%0d want 800/0/800/0",
               x0[0], vld0[0], x0[2], pc[2]);
    end
    @(negedge lcd_pclk);
    is_dying = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_saturate;
    @(negedge lcd_pclk);
    move_rate  = 4'd15;
    frame_tick = 1'b1;
    for (int k = 1; k <= 65540; k++) begin
      @(negedge lcd_pclk);
      if (k == 1) begin
        checks++;
        if (pc[3] !== 16'd0 || vld0[3] !== 1'b1 || x0[3] !== 11'd0) begin
          errs++;
          $display("FAIL sat_start: pc=%0d vld=%b x0=%0d want 0/1/0", pc[3], vld0[3], x0[3]);
        end
      end
      if (k == 2 || k == 65534 || k == 65535 || k == 65536 || k == 65540) begin
        checks++;
        if (pc[3] !== ((k - 1 > 65535) ? 16'hFFFF : 16'(k - 1))) begin
          errs++;
          $display("FAIL sat_count k=%0d: got %h want %h", k, pc[3],
                   (k - 1 > 65535) ? 16'hFFFF : 16'(k - 1));
        end
      end
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_spawn_move();
    test_gap();
    test_retire();
    test_rate_change();
    test_freeze();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
Schedules and moves the two cactus obstacle slots that feed the cactus sprite drawing and collision logic.
- Spawns each cactus at the right screen edge after a pseudo-random gap.
- Scrolls both slots left by move_rate pixels per frame.
- Retires slots that reach the left edge and counts them as passed obstacles (score).
- Motion follows the game controller's is_living / is_dying status.

Parameters:
H_DISP, 800, horizontal display width; spawn x-position (11-bit)
MIN_GAP, 200, minimum scroll distance in pixels between successive spawns
GAP_MASK, 8'hFF, mask applied to LFSR low byte to form the random extra gap
LFSR_SEED, 16'hACE1, non-zero LFSR reset value
Constraint: MIN_GAP + GAP_MASK <= 2047.

Ports:
lcd_pclk  in  1  clock; the single clock domain
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse, once per frame
is_living  in  1  game in PLAY state
is_dying  in  1  game in OVER state
move_rate  in  4  pixels scrolled per frame
cactus_vld_0  out  1  slot 0 occupied
cactus_x_0  out  11  slot 0 left x
cactus_vld_1  out  1  slot 1 occupied
cactus_x_1  out  11  slot 1 left x
spawn_pulse  out  1  one-cycle pulse on a spawn
passed_cnt  out  16  number of retired obstacles, saturating

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; vld_0 = vld_1 = 0; x_0 = x_1 = H_DISP.
  - gap_cnt=0, spawn_pulse=0, passed_cnt=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Galois, taps 16,14,13,11; advances every clock outside reset, in all states.
- States:
  - IDLE: go to RUN on the clock where is_living=1.
  - RUN: go to FREEZE on the clock where is_dying=1. is_dying has priority over the frame_tick in the same cycle, and that tick is discarded.
  - FREEZE: terminal; only rst exits. All outputs hold their values and ticks are ignored.
- frame_tick is ignored outside RUN.
- All outputs are registered. A tick's effects are visible on the cycle after frame_tick.
- Per tick in RUN, all decisions use the pre-tick register values:
  - For each valid slot:
    - if x < move_rate: retire (vld=0, x=H_DISP) and passed_cnt += 1, saturating at 16'hFFFF;
    - else x -= move_rate.
  - Two retirements on the same tick add 2 (saturating).
  - Spawn check:
    - if gap_cnt <= move_rate and a free slot exists (vld=0 pre-tick): spawn into the lowest-index free slot with vld=1, x=H_DISP. Then gap_cnt = MIN_GAP + (lfsr[7:0] & GAP_MASK) and spawn_pulse=1 for one cycle.
    - if gap_cnt <= move_rate and no slot is free: gap_cnt=0 and no spawn. The spawn then happens on the first tick where a slot is free pre-tick.
    - otherwise gap_cnt -= move_rate.
  - A slot that retires on a tick is not free for spawning until the next tick.
  - A freshly spawned slot does not move on its spawn tick.
- move_rate is sampled at each tick; a change takes effect on the next tick.
- move_rate=0:
  - no movement and no retirement;
  - gap_cnt is unchanged, unless gap_cnt=0 and a slot is free, in which case a spawn occurs.
- gap_cnt=0 after reset, so the first spawn happens on the first RUN tick.
- spawn_pulse is 0 on every cycle other than the one after a spawn tick.

Test Plan:
1. Reset, then 5 ticks with is_living=0 -> vld_0=vld_1=0, x_0=x_1=800, passed_cnt=0, spawn_pulse never 1.
2. is_living=1, move_rate=4, tick 1 -> cycle after: vld_0=1, x_0=800, spawn_pulse=1 for 1 cycle; tick 2 -> x_0=796; tick 11 -> x_0=760.
3. GAP_MASK=0, MIN_GAP=200, move_rate=4 -> slot 0 spawns at tick 1; slot 1 spawns at tick 51 (x_1=800); x_0=600 after tick 51.
4. GAP_MASK=0, MIN_GAP=8, move_rate=4 -> spawns at ticks 1 (slot 0) and 3 (slot 1); tick 5 no spawn, gap_cnt=0; slot 0 reaches x=0 at tick 201 and retires at tick 202 (passed_cnt=1); respawn into slot 0 at tick 203.
5. Mid-run is_dying=1 with x_0=700, then 10 ticks with move_rate changes -> all outputs frozen; asserting rst mid-frame immediately restores reset values (no clock needed).
6. move_rate 4->0 at tick 20 -> x_0 constant; restore to 7 -> x_0 decreases by 7 from the next tick; passed_cnt preset near 16'hFFFF saturates at 16'hFFFF.
